// File: rtl/program_loader.sv
// Boot loader: receives a header byte plus 4N little-endian data bytes over valid/ready,
// writes N words to instruction memory from address 0, then releases the processor.
module program_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_req,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              cpu_rst,
  output logic              start,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HEADER = 3'd1,
    S_DATA   = 3'd2,
    S_WRITE  = 3'd3,
    S_RUN    = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic [1:0]        bcnt_q, bcnt_d;
  logic [31:0]       word_q, word_d;
  logic              byte_ready_q, byte_ready_d;
  logic              im_we_q, im_we_d;
  logic              cpu_rst_q, cpu_rst_d;
  logic              start_q, start_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              accept;

  // Handshake: a byte transfers on a rising edge where byte_valid and byte_ready are
  // both high; byte_ready is registered, so it depends only on the current state.
  assign accept = byte_valid && byte_ready_q;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    last_d  = last_q;
    bcnt_d  = bcnt_q;
    word_d  = word_q;
    case (state_q)
      S_IDLE: begin
        if (load_req) state_d = S_HEADER;
      end
      S_HEADER: begin
        if (accept) begin
          // N-1 equals the header truncated to the address width, covering the
          // "count of 0 means full memory" case without extra logic.
          last_d  = ADDR_W'(byte_data);
          addr_d  = '0;
          bcnt_d  = 2'd0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (accept) begin
          word_d[{bcnt_q, 3'b000} +: 8] = byte_data;
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (addr_q == last_q) begin
          state_d = S_RUN;
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = S_DATA;
        end
      end
      S_RUN: begin
        if (load_req) state_d = S_HEADER;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they are registered and glitch-free.
    byte_ready_d = (state_d == S_HEADER) || (state_d == S_DATA);
    im_we_d      = (state_d == S_WRITE);
    busy_d       = (state_d == S_HEADER) || (state_d == S_DATA) || (state_d == S_WRITE);
    cpu_rst_d    = (state_d != S_RUN);
    start_d      = (state_d == S_RUN);
    done_d       = (state_q == S_WRITE) && (state_d == S_RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      last_q       <= '0;
      bcnt_q       <= 2'd0;
      word_q       <= 32'd0;
      byte_ready_q <= 1'b0;
      im_we_q      <= 1'b0;
      cpu_rst_q    <= 1'b1;
      start_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      last_q       <= last_d;
      bcnt_q       <= bcnt_d;
      word_q       <= word_d;
      byte_ready_q <= byte_ready_d;
      im_we_q      <= im_we_d;
      cpu_rst_q    <= cpu_rst_d;
      start_q      <= start_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign byte_ready = byte_ready_q;
  assign im_we      = im_we_q;
  assign im_addr    = addr_q;
  assign im_wdata   = word_q;
  assign cpu_rst    = cpu_rst_q;
  assign start      = start_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: drives byte streams, predicts the memory writes and load
// timing from the stream format, and checks every write, done pulse and start release.
module tb_program_loader;

  localparam int ADDR_W = 8;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk;
  logic              rst;
  logic              load_req;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_wdata;
  logic              cpu_rst;
  logic              start;
  logic              busy;
  logic              done;

  program_loader #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_req   (load_req),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .im_we      (im_we),
    .im_addr    (im_addr),
    .im_wdata   (im_wdata),
    .cpu_rst    (cpu_rst),
    .start      (start),
    .busy       (busy),
    .done       (done)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [ADDR_W+31:0] exp_q[$];
  logic [31:0]        prog_q[$];
  logic [ADDR_W+31:0] mon_e;
  int                 wr_cnt   = 0;
  int                 done_cnt = 0;
  logic               prev_we    = 1'b0;
  logic               prev_start = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      if (im_we) begin
        wr_cnt++;
        check("ready_in_write", byte_ready, 0);
        check("cpu_rst_in_write", cpu_rst, 1);
        if (exp_q.size() == 0) begin
          check("unexpected_write", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check("wr_addr", im_addr, mon_e[ADDR_W+31:32]);
          check("wr_data", im_wdata, mon_e[31:0]);
        end
      end
      if (done) begin
        done_cnt++;
        check("done_after_write", prev_we, 1);
        check("start_with_done", start, 1);
      end
      if (start && !prev_start) check("start_early", exp_q.size(), 0);
    end
    prev_we    = im_we;
    prev_start = start;
  end

  // Word count implied by a header byte.
  function automatic int n_of(input logic [7:0] hdr);
    int n;
    n = (int'(hdr) + 1) % DEPTH;
    if (n == 0) n = DEPTH;
    return n;
  endfunction

  // ---------------- drivers ----------------
  // Entered and left at a falling edge; offers one byte until it is accepted.
  task automatic send_byte(input logic [7:0] b, input int gap, input bit pulse_req);
    int w;
    byte_valid = 1'b0;
    repeat (gap) @(negedge clk);
    byte_valid = 1'b1;
    byte_data  = b;
    load_req   = pulse_req;
    w = 0;
    while (!byte_ready && w < 64) begin
      @(negedge clk);
      load_req = 1'b0;
      w++;
    end
    if (w >= 64) check("byte_timeout", 0, 1);
    @(negedge clk);
    load_req   = 1'b0;
    byte_valid = 1'b0;
  endtask

  task automatic run_load(input logic [7:0] hdr, input int gap_min, input int gap_max,
                          input int req_at, input bit from_run);
    int n, req_cyc, w, idx;
    logic [31:0] wd;
    n = n_of(hdr);
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back({ADDR_W'(i), prog_q[i]});
    wr_cnt   = 0;
    done_cnt = 0;
    @(negedge clk);
    load_req = 1'b1;
    req_cyc  = cyc;
    @(negedge clk);
    load_req = 1'b0;
    check("hdr_ready", byte_ready, 1);
    check("hdr_busy", busy, 1);
    check("hdr_cpu_rst", cpu_rst, 1);
    if (from_run) check("reload_start_low", start, 0);
    send_byte(hdr, $urandom_range(gap_min, gap_max), 1'b0);
    idx = 0;
    for (int i = 0; i < n; i++) begin
      wd = prog_q[i];
      for (int k = 0; k < 4; k++) begin
        send_byte(wd[8*k +: 8], $urandom_range(gap_min, gap_max), idx == req_at);
        idx++;
      end
    end
    w = 0;
    while (!start && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("start_seen", start, 1);
    if (gap_max == 0) check("load_cycles", cyc - req_cyc, 2 + 5 * n);
    @(negedge clk);
    #1;
    check("done_one_cycle", done, 0);
    check("done_count", done_cnt, 1);
    check("write_count", wr_cnt, n);
    check("exp_drained", exp_q.size(), 0);
    check("run_start", start, 1);
    check("run_cpu_rst", cpu_rst, 0);
    check("run_busy", busy, 0);
    check("run_ready", byte_ready, 0);
  endtask

  task automatic fill_demo();
    prog_q.delete();
    prog_q.push_back(32'h1234_5678);
    prog_q.push_back(32'hDEAD_BEEF);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ready"}, byte_ready, 0);
    check({tag, "_we"}, im_we, 0);
    check({tag, "_addr"}, im_addr, 0);
    check({tag, "_wdata"}, im_wdata, 0);
    check({tag, "_cpu_rst"}, cpu_rst, 1);
    check({tag, "_start"}, start, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int hdr_r, gmax, req_r;
    rst        = 1'b1;
    load_req   = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    repeat (2) @(negedge clk);
    check_reset_values("por");
    rst = 1'b0;
    @(negedge clk);
    check("idle_ready", byte_ready, 0);
    check("idle_cpu_rst", cpu_rst, 1);

    // Two-word load, no gaps.
    fill_demo();
    run_load(8'h01, 0, 0, -1, 1'b0);

    // Same stream with 3-cycle valid gaps, started from RUN.
    run_load(8'h01, 3, 3, -1, 1'b1);

    // load_req raised during DATA must be ignored.
    run_load(8'h01, 0, 0, 2, 1'b1);

    // Full-size load: word i = i.
    prog_q.delete();
    for (int i = 0; i < DEPTH; i++) prog_q.push_back(32'(i));
    run_load(8'hFF, 0, 0, -1, 1'b1);

    // Reset mid-load: word 0 written, word 1 partial.
    fill_demo();
    exp_q.delete();
    exp_q.push_back({ADDR_W'(0), prog_q[0]});
    wr_cnt = 0;
    @(negedge clk);
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
    send_byte(8'h01, 0, 1'b0);
    send_byte(8'h78, 0, 1'b0);
    send_byte(8'h56, 0, 1'b0);
    send_byte(8'h34, 0, 1'b0);
    send_byte(8'h12, 0, 1'b0);
    send_byte(8'hEF, 0, 1'b0);
    send_byte(8'hBE, 0, 1'b0);
    #1;
    check("mid_writes", wr_cnt, 1);
    check("mid_drained", exp_q.size(), 0);
    #2;
    rst = 1'b1;
    #1;
    check_reset_values("async");
    byte_valid = 1'b1;
    byte_data  = 8'hAD;
    repeat (3) @(negedge clk);
    check_reset_values("hold");
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_ready", byte_ready, 0);
      check("post_rst_cpu_rst", cpu_rst, 1);
    end
    byte_valid = 1'b0;

    // Fresh load after the interrupted one.
    prog_q.delete();
    prog_q.push_back(32'hCAFE_F00D);
    prog_q.push_back(32'h0BAD_5EED);
    prog_q.push_back(32'h0000_0001);
    run_load(8'h02, 0, 0, -1, 1'b0);

    // Randomized loads with random gaps and stray load_req pulses.
    for (int r = 0; r < 6; r++) begin
      hdr_r = $urandom_range(0, 9);
      prog_q.delete();
      for (int i = 0; i < n_of(8'(hdr_r)); i++) prog_q.push_back($urandom);
      gmax  = $urandom_range(0, 2);
      req_r = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 4 * n_of(8'(hdr_r)) - 1) : -1;
      run_load(8'(hdr_r), 0, gmax, req_r, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/program_loader.md
# program_loader

Boot-time front end of the single-cycle processor. It receives a program as a byte stream over a valid/ready handshake and packs the bytes into 32-bit little-endian words. It writes those words into the instruction memory, starting at word address 0. While loading it holds the processor in reset; once the last word is written it releases reset and raises the processor's `start` input, which it keeps high.

## Interface
Parameters:
- `ADDR_W`, default 8: instruction-memory word-address width, so the memory holds 2^ADDR_W words.

Ports:
- `clk`  in  1: the single system clock; all state changes on its rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `load_req`  in  1: request to start a new load. Sampled in IDLE and RUN only; ignored in every other state.
- `byte_valid`  in  1: `byte_data` holds a valid byte.
- `byte_data`  in  8: incoming stream byte.
- `byte_ready`  out  1: the loader accepts the byte this cycle.
- `im_we`  out  1: instruction-memory write enable.
- `im_addr`  out  ADDR_W: word address of the write.
- `im_wdata`  out  32: assembled word.
- `cpu_rst`  out  1: reset to the processor.
- `start`  out  1: processor start.
- `busy`  out  1: a load is in progress.
- `done`  out  1: one-cycle pulse when a load completes.

## Operation
- A byte is accepted on a rising edge when `byte_valid` and `byte_ready` are both 1.
- Stream format:
  - Byte 0 is the header H. The number of words is N = H+1, truncated to ADDR_W bits, where a count of 0 means 2^ADDR_W.
  - The header is followed by 4N data bytes, least-significant byte first.
- States: IDLE, HEADER, DATA, WRITE, RUN.
  - IDLE:
    - `cpu_rst`=1, `start`=0, `byte_ready`=0.
    - `load_req`=1 → HEADER.
  - HEADER:
    - `byte_ready`=1, `busy`=1, `cpu_rst`=1.
    - On accept, latch the word count, clear the address and byte counters, → DATA.
  - DATA:
    - `byte_ready`=1, `busy`=1.
    - Each accepted byte k (k = 0..3) goes into word bits [8k+7:8k].
    - The byte counter is 2 bits; it wraps from 3 to 0 on the fourth accept, and that accept → WRITE.
  - WRITE:
    - `byte_ready`=0, `im_we`=1 for exactly one cycle, `im_addr` = address counter, `im_wdata` = assembled word.
    - If the address counter equals N−1 → RUN; otherwise increment the address and → DATA.
  - RUN:
    - `cpu_rst`=0, `start`=1, `busy`=0.
    - `done`=1 in the first RUN cycle only.
    - `load_req`=1 → HEADER, with `cpu_rst`=1 and `start`=0 from that cycle on.
- `start` and `cpu_rst` are registered outputs, so they are glitch-free.
- The address counter is ADDR_W bits and never wraps past N−1, so a full-size load ends at 2^ADDR_W−1 and never overwrites address 0.
- Bytes presented with `byte_valid` in IDLE, WRITE or RUN are not accepted; `byte_ready` is 0 in those states.
- An assertion of `rst` in any state returns the block to IDLE immediately and discards any partial word. Words already written stay in memory.

## Timing
- Reset values:
  - `byte_ready`=0, `im_we`=0, `im_addr`=0, `im_wdata`=0.
  - `cpu_rst`=1, `start`=0, `busy`=0, `done`=0.
  - State = IDLE.
- `load_req` sampled high at edge t: HEADER holds from t; `byte_ready`=1 is visible in the cycle after t.
- Fourth byte of a word accepted at edge t: `im_we`=1 during the cycle from t to t+1; the write lands at edge t+1.
- The earliest next-byte accept is at edge t+2. Peak throughput is 4 bytes per 5 cycles.
- Last write at edge t+1: `start`=1, `cpu_rst`=0 and `done`=1 from edge t+1. `done` clears at t+2.
- Minimum load time for N words with a stream that never stalls: 1 (request) + 1 (header) + 5N cycles.
- `byte_valid` gaps stall DATA without changing the byte counter or the partial word.

## Test plan
- Reset: assert `rst` mid-cycle, asynchronously → all outputs take their reset values immediately. Hold for 3 cycles → values stay.
- Two-word load:
  - Stimulus: `load_req`, then header 0x01, then bytes 78 56 34 12 EF BE AD DE with no gaps.
  - Required: writes addr0=0x12345678 and addr1=0xDEADBEEF, exactly two `im_we` pulses, then `start`=1, `cpu_rst`=0 and a single `done` pulse one cycle after the second write.
- Backpressure/stall: same stream with `byte_valid` dropped for 3 cycles between every byte → identical writes. Bytes offered during WRITE are not consumed.
- Full size:
  - Stimulus: header 0xFF (ADDR_W=8), 1024 data bytes with word i = i.
  - Required: 256 writes at addresses 0..255, address 0 written only once, `start` after the write to address 255.
- Reset mid-load: assert `rst` after 6 data bytes (word 0 written, word 1 partial) → IDLE, `cpu_rst`=1, no further `im_we`. A fresh load then completes correctly.
- Reload from RUN:
  - `load_req` while running → `start`=0 and `cpu_rst`=1 on the next edge, new header accepted, new program written, `start` reasserted.
  - `load_req` during DATA → ignored.
